// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control blocks of the 5-stage MIPS core.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    REDIR   = 2'd2,
    HALT    = 2'd3
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear takes priority over increment so a reset cycle never counts.
  always_ff @(posedge CLK) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, EX redirects, dmem waits and halt.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             mem_halt,
  input  logic             ex_redirect,
  input  logic             idex_dREN,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             pc_we,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state, next_state;
  logic memstall, lu, redir_event, stall_event;

  assign memstall = mem_req & ~dhit;
  assign lu = idex_dREN & (idex_rt != REG_W'(REG_ZERO)) &
              ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  always_ff @(posedge CLK) begin
    if (RST)
      state <= RUN;
    else
      state <= next_state;
  end

  // Mealy control decode; a memstall freezes everything, including a pending redirect.
  always_comb begin
    next_state  = state;
    pc_we       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b0;
    redir_event = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          if (mem_halt) begin
            halted     = 1'b1;
            next_state = HALT;
          end else if (memstall) begin
            next_state = MEMWAIT;
          end else if (ex_redirect) begin
            pc_we       = ihit;
            exmem_en    = ihit;
            memwb_en    = ihit;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            redir_event = 1'b1;
            next_state  = ihit ? RUN : REDIR;
          end else if (lu) begin
            idex_flush = ihit;
            exmem_en   = ihit;
            memwb_en   = ihit;
          end else begin
            pc_we    = ihit;
            ifid_en  = ihit;
            idex_en  = ihit;
            exmem_en = ihit;
            memwb_en = ihit;
          end
        end
        MEMWAIT: begin
          if (dhit) begin
            pc_we      = ihit;
            ifid_en    = ihit;
            idex_en    = ihit;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            next_state = RUN;
          end
        end
        // Flushes stay asserted until the fetch completes so they are not lost.
        REDIR: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pc_we      = ihit;
          exmem_en   = ihit;
          memwb_en   = ihit;
          if (ihit)
            next_state = RUN;
        end
        HALT: begin
          halted = 1'b1;
        end
      endcase
    end
  end

  assign stall_event = ~RST & (state != HALT) & ~pc_we;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (stall_event),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (redir_event),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cycles with expected controls queued per cycle.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, mem_req, mem_halt, ex_redirect;
  logic        idex_dREN, ifid_uses_rt;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [15:0] expStall = '0;
  logic [15:0] expFlush = '0;
  bit          tbHalt = 1'b0;
  logic [7:0]  expQ[$];
  string       tagQ[$];

  // Control bit order: pc_we ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en halted
  localparam logic [7:0] C_ZERO   = 8'b0000_0000;
  localparam logic [7:0] C_NORMAL = 8'b1101_0110;
  localparam logic [7:0] C_LU     = 8'b0000_1110;
  localparam logic [7:0] C_RD_MIS = 8'b0010_1000;
  localparam logic [7:0] C_RD_HIT = 8'b1010_1110;
  localparam logic [7:0] C_HALT   = 8'b0000_0001;
  localparam logic [7:0] C_DHIT_NOI = 8'b0000_0110;

  hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_req      (mem_req),
    .mem_halt     (mem_halt),
    .ex_redirect  (ex_redirect),
    .idex_dREN    (idex_dREN),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .pc_we        (pc_we),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCycle();
    logic [7:0] e;
    string      t;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput({t, "_ctrl"},
                {24'b0, pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted},
                {24'b0, e});
    checkOutput({t, "_stall_cnt"}, {16'b0, stall_cnt}, {16'b0, expStall});
    checkOutput({t, "_flush_cnt"}, {16'b0, flush_cnt}, {16'b0, expFlush});
  endtask

  // One cycle: inputs already driven just after the edge, sampled mid-cycle, then the edge.
  task automatic applyStimulus(input string tag, input logic [7:0] expCtrl, input bit redir);
    expQ.push_back(expCtrl);
    tagQ.push_back(tag);
    #4;
    checkCycle();
    @(posedge CLK);
    #1;
    if (RST) begin
      expStall = '0;
      expFlush = '0;
      tbHalt   = 1'b0;
    end else begin
      if (!tbHalt && !expCtrl[7] && expStall != 16'hFFFF) expStall++;
      if (redir && expFlush != 16'hFFFF) expFlush++;
      if (expCtrl[0]) tbHalt = 1'b1;
    end
  endtask

  task automatic setIdle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; mem_halt = 1'b0;
    ex_redirect = 1'b0; idex_dREN = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0;
    ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
  endtask

  task automatic doReset();
    setIdle();
    ihit = 1'b0;
    RST  = 1'b1;
    applyStimulus("reset", C_ZERO, 1'b0);
    setIdle();
  endtask

  initial begin
    setIdle();
    RST = 1'b1;
    ihit = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    doReset();
    ihit = 1'b0;
    applyStimulus("post_reset_idle", C_ZERO, 1'b0);

    // Load-use on rs, then clear, then r0 destination, then rt match.
    doReset();
    idex_dREN = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    applyStimulus("lu_rs", C_LU, 1'b0);
    idex_dREN = 1'b0;
    applyStimulus("lu_after", C_NORMAL, 1'b0);
    idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    applyStimulus("lu_r0", C_NORMAL, 1'b0);
    idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
    applyStimulus("lu_rt", C_LU, 1'b0);
    ifid_uses_rt = 1'b0;
    applyStimulus("lu_rt_unused", C_NORMAL, 1'b0);
    ifid_uses_rt = 1'b1; ihit = 1'b0;
    applyStimulus("lu_nohit", C_ZERO, 1'b0);
    setIdle();
    applyStimulus("lu_done", C_NORMAL, 1'b0);

    // Redirect while fetch misses: flush held through REDIR until ihit.
    doReset();
    ex_redirect = 1'b1; ihit = 1'b0;
    applyStimulus("redir_run", C_RD_MIS, 1'b1);
    applyStimulus("redir_wait1", C_RD_MIS, 1'b0);
    applyStimulus("redir_wait2", C_RD_MIS, 1'b0);
    ihit = 1'b1;
    applyStimulus("redir_ihit", C_RD_HIT, 1'b0);
    ex_redirect = 1'b0;
    applyStimulus("redir_done", C_NORMAL, 1'b0);
    ex_redirect = 1'b1;
    applyStimulus("redir_fast", C_RD_HIT, 1'b1);
    ex_redirect = 1'b0;
    applyStimulus("redir_fast_done", C_NORMAL, 1'b0);

    // Data memory wait of four cycles.
    doReset();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus($sformatf("memwait%0d", i), C_ZERO, 1'b0);
    dhit = 1'b1;
    applyStimulus("memwait_dhit", C_NORMAL, 1'b0);
    mem_req = 1'b0; dhit = 1'b0;
    applyStimulus("memwait_done", C_NORMAL, 1'b0);
    mem_req = 1'b1;
    applyStimulus("memwait2_0", C_ZERO, 1'b0);
    dhit = 1'b1; ihit = 1'b0;
    applyStimulus("memwait2_dhit_noi", C_DHIT_NOI, 1'b0);

    // Memstall, redirect and load-use together.
    doReset();
    mem_req = 1'b1; ex_redirect = 1'b1; idex_dREN = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    applyStimulus("combo_freeze0", C_ZERO, 1'b0);
    applyStimulus("combo_freeze1", C_ZERO, 1'b0);
    dhit = 1'b1;
    applyStimulus("combo_dhit", C_NORMAL, 1'b0);
    mem_req = 1'b0; dhit = 1'b0;
    applyStimulus("combo_redir", C_RD_HIT, 1'b1);
    setIdle();
    applyStimulus("combo_done", C_NORMAL, 1'b0);

    // Reset in the middle of REDIR drops the pending flush.
    doReset();
    ex_redirect = 1'b1; ihit = 1'b0;
    applyStimulus("rst_redir_enter", C_RD_MIS, 1'b1);
    applyStimulus("rst_redir_hold", C_RD_MIS, 1'b0);
    doReset();
    applyStimulus("rst_redir_after", C_NORMAL, 1'b0);

    // Halt is sticky regardless of ihit until reset.
    doReset();
    mem_halt = 1'b1;
    applyStimulus("halt_enter", C_HALT, 1'b0);
    mem_halt = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus($sformatf("halt_hold%0d", i), C_HALT, 1'b0);
    doReset();
    applyStimulus("halt_cleared", C_NORMAL, 1'b0);

    // Halt beats a simultaneous memstall.
    mem_halt = 1'b1; mem_req = 1'b1;
    applyStimulus("halt_vs_mem", C_HALT, 1'b0);
    setIdle();
    applyStimulus("halt_vs_mem_hold", C_HALT, 1'b0);

    // Stall counter saturation.
    doReset();
    ihit = 1'b0;
    for (int i = 0; i < 65541; i++) begin
      @(posedge CLK);
      if (expStall != 16'hFFFF) expStall++;
    end
    #1;
    applyStimulus("sat_hold", C_ZERO, 1'b0);
    applyStimulus("sat_final", C_ZERO, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
